// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter sharing one fixed-latency ALU, one op in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter #(
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic [5:0] req_sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [3:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_result,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d;
   logic [2:0] alu_sel_q, alu_sel_d;
   logic       rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
   logic       gnt_id, accept;
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
   assign gnt_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];
   assign last_d = accept ? gnt_id : last_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
`else
   assign gnt_id = ~req_valid[0];
`endif
   // req_ready is forced low while reset is asserted, even though state is already IDLE
   assign req_ready  = (rst_n && state_q == IDLE && |req_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
   assign accept     = |(req_valid & req_ready);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = state_q != IDLE;
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      if (accept) begin
         alu_a_d   = gnt_id ? req_a[7:4] : req_a[3:0];
         alu_b_d   = gnt_id ? req_b[7:4] : req_b[3:0];
         alu_sel_d = gnt_id ? req_sel[5:3] : req_sel[2:0];
         rsp_id_d  = gnt_id;
         cnt_d     = 3'(ALU_LAT);
         state_d   = WAIT;
      end else if (state_q == WAIT) begin
         cnt_d = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
         if (cnt_q == 3'd0) begin
            rsp_result_d = alu_result;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
      end else if (state_q == RESP && rsp_ready) begin
         rsp_valid_d = 1'b0;
         state_d     = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
      end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a pipelined ALU model of latency LAT.
module tb_alu_arbiter;
   localparam int LAT = 1;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [1:0] req_valid, req_ready;
   logic [7:0] req_a, req_b;
   logic [5:0] req_sel;
   logic [3:0] alu_a, alu_b, alu_result, rsp_result;
   logic [2:0] alu_sel;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   int         errors = 0, checks = 0;
   logic       last = 1'b1;
   logic [10:0] last_ops = '0;
   logic [4:0] sb[$];
   logic [3:0] pipe[LAT];

   always #5 clk = ~clk;

   alu_arbiter #(.ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sel(alu_sel), .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
   );

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
      case (s)
         3'd0:    return b;
         3'd1:    return a;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // the ALU result only becomes valid LAT cycles after the operands change
   always @(posedge clk) begin
      pipe[0] <= alu_f(alu_a, alu_b, alu_sel);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign alu_result = pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic op(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                     input logic [5:0] s, input int bp);
      logic       id;
      logic [3:0] ea, eb;
      logic [2:0] es;
      logic [4:0] exp;
      int         k;
      req_valid = v; req_a = a; req_b = b; req_sel = s;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      id = (v == 2'b11) ? ~last : v[1];
`else
      id = ~v[0];
`endif
      last = id;
      ea = id ? a[7:4] : a[3:0];
      eb = id ? b[7:4] : b[3:0];
      es = id ? s[5:3] : s[2:0];
      last_ops = {ea, eb, es};
      #1 check("req_ready", req_ready, id ? 2'b10 : 2'b01);
      sb.push_back({id, alu_f(ea, eb, es)});
      @(posedge clk);
      @(negedge clk);
      check("alu_ops", {alu_a, alu_b, alu_sel}, {ea, eb, es});
      check("wait_ready_busy", {req_ready, busy}, 3'b001);
      req_a = 8'($urandom); req_b = 8'($urandom); req_sel = 6'($urandom);
      k = 1;
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("latency", k, LAT + 2);
      exp = sb.pop_front();
      check("rsp", {rsp_id, rsp_result}, exp);
      repeat (bp) begin
         @(negedge clk);
         check("backpressure", {rsp_valid, rsp_id, rsp_result, req_ready, busy}, {1'b1, exp, 2'b00, 1'b1});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("handshake", {rsp_valid, busy}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      req_valid = 2'b00; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
      #2 req_valid = 2'b11;
      #1 check("reset_state", {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, busy}, 0);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op(2'b01, 8'h07, 8'h05, 6'b000_010, 0);
      req_valid = 2'b00;
      op(2'b10, 8'hF0, 8'h10, 6'b010_000, 0);
      op(2'b10, 8'h50, 8'h70, 6'b011_000, 0);
      req_valid = 2'b00;
      for (int s = 0; s < 8; s++) op(2'b01, 8'($urandom), 8'($urandom), {3'($urandom), 3'(s)}, 0);
      op(2'b01, 8'h3A, 8'h5C, 6'b000_100, 5);
      req_valid = 2'b00;
      repeat (4) op(2'b11, 8'h77, 8'h55, 6'b001_000, 0);
      op(2'b10, 8'h77, 8'h55, 6'b001_000, 0);
      req_valid = 2'b00;
      // a request withdrawn before any clock edge must leave no trace
      req_valid = 2'b01; req_a = 8'hFF; req_b = 8'hFF; req_sel = 6'h3F;
      #1 req_valid = 2'b00;
      repeat (2) @(negedge clk);
      check("cancel", {busy, rsp_valid, alu_a, alu_b, alu_sel}, {2'b00, last_ops});
      // reset while an op is waiting on the ALU
      req_valid = 2'b01; req_a = 8'h12; req_b = 8'h34; req_sel = 6'h02;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      #1 rst_n = 1'b0;
      #1 check("async_reset", {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, busy}, 0);
      sb.delete();
      last = 1'b1;
      @(negedge clk);
      check("reset_hold", {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, busy}, 0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("no_stale_rsp", {rsp_valid, busy}, 2'b00);
      end
      op(2'b01, 8'h09, 8'h03, 6'b000_011, 0);
      req_valid = 2'b00;
      repeat (2) op(2'b11, 8'h77, 8'h55, 6'b001_000, 0);
      req_valid = 2'b00;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
